// File: rtl/ram_pkg.sv
// Shared types for the RAM access controller: default widths, command opcodes and FSM states.
package ram_pkg;

  localparam int unsigned RAM_ADDR_W = 4;
  localparam int unsigned RAM_DATA_W = 16;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_FILL  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    RESP  = 3'd3,
    FILL  = 3'd4
  } state_e;

endpackage

// File: rtl/ram_access_ctrl.sv
// Sequences read/write/fill commands onto a single-port RAM (rising-edge write,
// falling-edge registered read) and returns read data over a valid/ready channel.
module ram_access_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned DATA_W = RAM_DATA_W,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              accept;

  assign accept = req_valid && req_ready_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;

    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (accept) begin
          unique case (op_e'(req_op))
            OP_READ: begin
              mem_addr_d  = req_addr;
              rsp_addr_d  = req_addr;
              req_ready_d = 1'b0;
              state_d     = READ;
            end
            OP_WRITE: begin
              mem_addr_d  = req_addr;
              mem_wdata_d = req_wdata;
              mem_we_d    = 1'b1;
              req_ready_d = 1'b0;
              state_d     = WRITE;
            end
            OP_FILL: begin
              mem_addr_d  = '0;
              mem_wdata_d = req_wdata;
              mem_we_d    = 1'b1;
              cnt_d       = '0;
              req_ready_d = 1'b0;
              state_d     = FILL;
            end
            default: ;
          endcase
        end
      end
      WRITE: begin
        mem_we_d    = 1'b0;
        req_ready_d = 1'b1;
        state_d     = IDLE;
      end
      READ: begin
        rsp_data_d  = mem_rdata;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      FILL: begin
        // The word at mem_addr is committed on this edge; stop once the last one is.
        if (cnt_q == FILL_LAST) begin
          mem_we_d    = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d      = CNT_W'(cnt_q + CNT_W'(1));
          mem_addr_d = ADDR_W'(cnt_d);
        end
      end
      default: begin
        mem_we_d    = 1'b0;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_addr  = rsp_addr_q;
  assign busy      = busy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl driving a behavioural 16x16 RAM
// (rising-edge write, falling-edge registered read).
module tb_ram_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [3:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_addr;
  logic        busy;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;

  logic [15:0] ram [16];

  int tests;
  int fails;

  ram_access_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: write on rising edge, read registered on falling edge
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
  always @(negedge clk) mem_rdata <= ram[mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for req_ready, present one request, and return just after its acceptance edge.
  task automatic issue(input logic [1:0] op, input logic [3:0] addr, input logic [15:0] data);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) begin
      tests++; fails++;
      $display("FAIL issue_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
    end
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = data;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) tick();
    tests++;
    if ({req_ready, rsp_valid, busy, mem_we} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got %b required 0000", {req_ready, rsp_valid, busy, mem_we});
    end
    tests++;
    if ({mem_addr, mem_wdata, rsp_data, rsp_addr} !== 40'h0) begin
      fails++; $display("FAIL reset_buses: got %h required 0", {mem_addr, mem_wdata, rsp_data, rsp_addr});
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_release: req_ready=%b busy=%b required 1/0", req_ready, busy);
    end
  endtask

  task automatic test_write_read();
    rsp_ready = 1'b1;
    issue(2'b01, 4'd5, 16'hBEEF);
    tests++;
    if (mem_we !== 1'b1 || mem_addr !== 4'd5 || mem_wdata !== 16'hBEEF || busy !== 1'b1 || req_ready !== 1'b0) begin
      fails++; $display("FAIL write_issue: we=%b addr=%h wdata=%h busy=%b rdy=%b required 1/5/beef/1/0",
                        mem_we, mem_addr, mem_wdata, busy, req_ready);
    end
    tick();
    tests++;
    if (mem_we !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL write_done: we=%b rdy=%b busy=%b required 0/1/0", mem_we, req_ready, busy);
    end
    issue(2'b00, 4'd5, 16'h0000);
    tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || mem_addr !== 4'd5) begin
      fails++; $display("FAIL read_accept: vld=%b busy=%b addr=%h required 0/1/5", rsp_valid, busy, mem_addr);
    end
    tick();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF || rsp_addr !== 4'd5 || req_ready !== 1'b0) begin
      fails++; $display("FAIL read_rsp: vld=%b data=%h addr=%h rdy=%b required 1/beef/5/0",
                        rsp_valid, rsp_data, rsp_addr, req_ready);
    end
    tick();
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL read_done: vld=%b rdy=%b required 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    issue(2'b00, 4'd5, 16'h0000);
    tick();
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF || req_ready !== 1'b0 || busy !== 1'b1) begin
        fails++; $display("FAIL bp_hold[%0d]: vld=%b data=%h rdy=%b busy=%b required 1/beef/0/1",
                          i, rsp_valid, rsp_data, req_ready, busy);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL bp_release: vld=%b rdy=%b required 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_fill();
    logic [3:0] raddr [3];
    raddr[0] = 4'd0; raddr[1] = 4'd7; raddr[2] = 4'd15;
    rsp_ready = 1'b1;
    issue(2'b10, 4'd9, 16'hA5A5);
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (mem_we !== 1'b1 || mem_addr !== 4'(i) || mem_wdata !== 16'hA5A5 || busy !== 1'b1 || req_ready !== 1'b0) begin
        fails++; $display("FAIL fill_seq[%0d]: we=%b addr=%0d wdata=%h busy=%b rdy=%b required 1/%0d/a5a5/1/0",
                          i, mem_we, mem_addr, mem_wdata, busy, req_ready, i);
      end
      tick();
    end
    tests++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL fill_end: we=%b busy=%b rdy=%b required 0/0/1", mem_we, busy, req_ready);
    end
    for (int k = 0; k < 3; k++) begin
      issue(2'b00, raddr[k], 16'h0000);
      tick();
      tests++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'hA5A5 || rsp_addr !== raddr[k]) begin
        fails++; $display("FAIL fill_read[%0d]: vld=%b data=%h addr=%0d required 1/a5a5/%0d",
                          k, rsp_valid, rsp_data, rsp_addr, raddr[k]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    issue(2'b01, 4'd3, 16'h1234);
    tick();
    issue(2'b00, 4'd3, 16'h0000);
    tick();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h1234 || rsp_addr !== 4'd3) begin
      fails++; $display("FAIL b2b_read: vld=%b data=%h addr=%0d required 1/1234/3", rsp_valid, rsp_data, rsp_addr);
    end
    tick();
    issue(2'b11, 4'd3, 16'hDEAD);
    tests++;
    if (mem_we !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL rsvd_op: we=%b vld=%b rdy=%b busy=%b required 0/0/1/0", mem_we, rsp_valid, req_ready, busy);
    end
    tick();
    tests++;
    if (mem_we !== 1'b0 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL rsvd_quiet: we=%b vld=%b required 0/0", mem_we, rsp_valid);
    end
    issue(2'b00, 4'd3, 16'h0000);
    tick();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h1234) begin
      fails++; $display("FAIL rsvd_read: vld=%b data=%h required 1/1234", rsp_valid, rsp_data);
    end
    tick();
  endtask

  task automatic test_reset_mid_fill();
    logic [15:0] exp;
    rsp_ready = 1'b1;
    issue(2'b10, 4'd0, 16'h5A5A);
    repeat (6) tick();
    tests++;
    if (mem_addr !== 4'd6 || mem_we !== 1'b1) begin
      fails++; $display("FAIL midfill_pos: addr=%0d we=%b required 6/1", mem_addr, mem_we);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || mem_addr !== 4'd0) begin
      fails++; $display("FAIL midfill_async: we=%b busy=%b addr=%0d required 0/0/0", mem_we, busy, mem_addr);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      exp = (i < 6) ? 16'h5A5A : 16'hA5A5;
      issue(2'b00, 4'(i), 16'h0000);
      tick();
      tests++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp) begin
        fails++; $display("FAIL midfill_read[%0d]: vld=%b data=%h required 1/%h", i, rsp_valid, rsp_data, exp);
      end
      tick();
    end
  endtask

  task automatic test_reset_in_resp();
    rsp_ready = 1'b0;
    issue(2'b00, 4'd7, 16'h0000);
    tick();
    rst_n = 1'b0;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || rsp_data !== 16'h0000 || req_ready !== 1'b0) begin
      fails++; $display("FAIL resp_reset: vld=%b data=%h rdy=%b required 0/0000/0", rsp_valid, rsp_data, req_ready);
    end
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    tick();
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL resp_after: vld=%b rdy=%b required 0/1", rsp_valid, req_ready);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 16; i++) ram[i] <= 16'h1100 + 16'(i);
    test_reset();
    test_write_read();
    test_backpressure();
    test_fill();
    test_back_to_back();
    test_reset_mid_fill();
    test_reset_in_resp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
